// File: rtl/alu_mc_pkg.sv
// Shared opcode encoding, FSM state codes and opcode classification helpers for alu_mc.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_CONV = 4'b1111;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_CONV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB,
            OP_SRL, OP_MUL, OP_XOR, OP_SLT, OP_CONV: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mac_iter.sv
// Iterative accumulate datapath shared by MUL (one multiplier bit per cycle, LSB first)
// and CONV (one unsigned lane MAC per cycle, lane 0 first).
module mac_iter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned LANES = WIDTH / LANE_W;
    localparam int unsigned CW    = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             mode_q;
    logic [CW-1:0]    last;

    // mode 0: partial product for multiplier bit idx; mode 1: product of lane idx
    function automatic logic [WIDTH-1:0] term(input logic m, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [CW-1:0] idx);
        logic [WIDTH-1:0]  xs, ys;
        logic [LANE_W-1:0] la, lb;
        int unsigned       sh;
        if (m) begin
            sh = int'(idx) * LANE_W;
            xs = x >> sh;
            ys = y >> sh;
            la = xs[LANE_W-1:0];
            lb = ys[LANE_W-1:0];
            return WIDTH'(la) * WIDTH'(lb);
        end
        return y[idx] ? (x << idx) : '0;
    endfunction

    assign last = mode_q ? CW'(LANES - 1) : CW'(WIDTH - 1);
    assign done = run_q && (cnt_q == last);
    assign acc  = acc_q;

    // The first iteration runs on the start edge so the caller sees the nominal latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            mode_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            acc_q  <= term(mode, a, b, '0);
            cnt_q  <= CW'(1);
            run_q  <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_q + term(mode_q, a_q, b_q, cnt_q);
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops are computed here,
// MUL and CONV are delegated to mac_iter.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             illegal_op,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ill_q, ill_d;
    logic             sel_mac_q, sel_mac_d;
    logic             accept;
    logic             mac_start;
    logic             mac_done;
    logic [WIDTH-1:0] mac_acc;
    logic [WIDTH-1:0] single_res;

    assign accept = in_valid && in_ready;

    always_comb begin
        single_res = '0;
        case (alu_control)
            OP_AND:  single_res = in1 & in2;
            OP_OR:   single_res = in1 | in2;
            OP_ADD:  single_res = in1 + in2;
            OP_SUB:  single_res = in1 - in2;
            OP_XOR:  single_res = in1 ^ in2;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SLL:  single_res = in1 << in2[SHW-1:0];
            OP_SRL:  single_res = in1 >> in2[SHW-1:0];
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        ill_d     = ill_q;
        sel_mac_d = sel_mac_q;
        mac_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_legal(alu_control)) begin
                        res_d     = '0;
                        ill_d     = 1'b1;
                        sel_mac_d = 1'b0;
                        state_d   = DONE;
                    end else if (is_multicycle(alu_control)) begin
                        mac_start = 1'b1;
                        ill_d     = 1'b0;
                        sel_mac_d = 1'b1;
                        state_d   = EXEC;
                    end else begin
                        res_d     = single_res;
                        ill_d     = 1'b0;
                        sel_mac_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            EXEC: begin
                if (mac_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            res_q     <= '0;
            ill_q     <= 1'b0;
            sel_mac_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            ill_q     <= ill_d;
            sel_mac_q <= sel_mac_d;
        end
    end

    mac_iter #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W)
    ) u_mac_iter (
        .clk   (clk),
        .reset (reset),
        .start (mac_start),
        .mode  (alu_control == OP_CONV),
        .a     (in1),
        .b     (in2),
        .done  (mac_done),
        .acc   (mac_acc)
    );

    // The accumulator is frozen once mac_iter finishes, so it acts as the result register.
    assign alu_result = sel_mac_q ? mac_acc : res_q;
    assign out_valid  = (state_q == DONE);
    assign zero_flag  = out_valid && (alu_result == '0);
    assign illegal_op = ill_q;
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes hand-computed results, a monitor pops and
// compares them whenever a result is handed off.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] in1, in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic        illegal_op;
    logic        busy;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_mc #(
        .WIDTH  (32),
        .LANE_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .illegal_op  (illegal_op),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed when out_valid && out_ready before a rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".result"}, alu_result, e.res);
                    check({e.name, ".zero"}, 32'(zero_flag), 32'(e.zero));
                    check({e.name, ".illegal"}, 32'(illegal_op), 32'(e.ill));
                end
            end
        end
    end

    // Returns at the negedge of cycle T+1, with inputs already scrambled.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic ill);
        int k;
        exp_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        alu_control = op;
        in1         = a;
        in2         = b;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check({name, ".accept_timeout"}, 32'd1, 32'd0);
        e.name = name;
        e.res  = res;
        e.zero = z;
        e.ill  = ill;
        sb.push_back(e);
        @(negedge clk);
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        in1         = $urandom;
        in2         = $urandom;
    endtask

    task automatic wait_valid(input string name, input int lat, input bit chk_busy);
        int n;
        bit bad;
        n   = 1;
        bad = 1'b0;
        while (!out_valid && n < 200) begin
            if (chk_busy && (!busy || in_ready)) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, 32'(n), 32'(lat));
        if (chk_busy) check({name, ".busy_in_exec"}, 32'(bad), 32'd0);
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic z,
                       input logic ill, input int lat);
        issue(name, op, a, b, res, z, ill);
        wait_valid(name, lat, lat > 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        alu_control = 4'b0;
        in1         = '0;
        in2         = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.result", alu_result, 32'd0);
        check("reset.zero", 32'(zero_flag), 32'd0);
        check("reset.illegal", 32'(illegal_op), 32'd0);

        run("add",   4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1);
        run("sub",   4'b0100, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 1);
        run("sll",   4'b0011, 32'd1,          32'h0000_0024,  32'h10,         1'b0, 1'b0, 1);
        run("and",   4'b0000, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0, 1'b0, 1);
        run("or",    4'b0001, 32'h12,         32'h21,         32'h33,         1'b0, 1'b0, 1);
        run("xor",   4'b0111, 32'hF0F0,       32'hFFFF,       32'h0F0F,       1'b0, 1'b0, 1);
        run("srl",   4'b0101, 32'h8000_0000,  32'h0000_003F,  32'h1,          1'b0, 1'b0, 1);
        run("slt_t", 4'b1000, 32'd3,          32'd5,          32'd1,          1'b0, 1'b0, 1);
        run("slt_u", 4'b1000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1);
        run("mul1",  4'b0110, 32'h0001_0003,  32'd5,          32'h0005_000F,  1'b0, 1'b0, 32);
        run("mul2",  4'b0110, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0, 32);
        run("conv1", 4'b1111, 32'h0102_0304,  32'h0506_0708,  32'd70,         1'b0, 1'b0, 4);
        run("conv2", 4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0003_F804,  1'b0, 1'b0, 4);
        run("illeg", 4'b1001, 32'd123,        32'd456,        32'd0,          1'b1, 1'b1, 1);

        // Backpressure: result must be held while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        run("bp_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.hold_result", alu_result, 32'd2);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.idle_in_ready", 32'(in_ready), 32'd1);
        check("bp.idle_valid", 32'(out_valid), 32'd0);
        check("bp.idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a MUL discards it.
        issue("mul_abort", 4'b0110, 32'h1234_5678, 32'h9, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.busy", 32'(busy), 32'd0);
        run("add_after", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
